writeback_ctrl: RTL

//  Write side of the scalar/vector register file. Accepts results from the vector ALU (whole vector)
//  and from the load unit (one element per beat), queues and assembles them, and drives the register

---
 rtl/asip_wb_pkg.sv | 31 +++
 rtl/wb_fifo.sv | 64 ++++++
 rtl/writeback_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/asip_wb_pkg.sv
// Shared types for the register-file writeback block.
// Provides the queued-result record, the load-assembler state encoding,
// file geometry constants and a destination-index to bit-mask helper.
package asip_wb_pkg;

  localparam int unsigned REG_SIZE = 8;   // bits per element / scalar register
  localparam int unsigned REG_QTY  = 8;   // registers per file
  localparam int unsigned VEC_SIZE = 4;   // elements per vector register
  localparam int unsigned RW       = $clog2(REG_QTY);
  localparam int unsigned LW       = (VEC_SIZE > 1) ? $clog2(VEC_SIZE) : 1;

  typedef logic [VEC_SIZE-1:0][REG_SIZE-1:0] vec_data_t;

  typedef struct packed {
    logic            isVec;
    logic [RW-1:0]   dest;
    vec_data_t       data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    ASM_IDLE    = 2'd0,
    ASM_COLLECT = 2'd1,
    ASM_WAIT    = 2'd2
  } asm_state_t;

  function automatic logic [REG_QTY-1:0] dest_mask(input logic [RW-1:0] dest);
    dest_mask       = '0;
    dest_mask[dest] = 1'b1;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small ring-buffer queue of writeback entries with synchronous reset.
// Ports:
//   clk_i, reset_i      clock, synchronous active-high reset
//   push_i/push_data_i  enqueue request (ignored while full, even if popping)
//   pop_i               dequeue request (ignored while empty)
//   head_o              oldest entry
//   full_o/empty_o      occupancy flags
//   entries_o/valid_o   raw storage and per-slot valid bits (for hazard masks)
module wb_fifo
  import asip_wb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         push_i,
  input  wb_entry_t                    push_data_i,
  input  logic                         pop_i,
  output wb_entry_t                    head_o,
  output logic                         full_o,
  output logic                         empty_o,
  output wb_entry_t [FIFO_DEPTH-1:0]   entries_o,
  output logic      [FIFO_DEPTH-1:0]   valid_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  wb_entry_t [FIFO_DEPTH-1:0] mem_q;
  logic      [FIFO_DEPTH-1:0] valid_q;
  logic      [AW-1:0]         wr_ptr_q;
  logic      [AW-1:0]         rd_ptr_q;
  logic                       do_push;
  logic                       do_pop;

  // Per-slot valid bits make full/empty trivial; push and pop can never hit
  // the same slot because that would require the queue to be both not full
  // and not empty with equal pointers.
  assign full_o    = &valid_q;
  assign empty_o   = ~|valid_q;
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;
  assign head_o    = mem_q[rd_ptr_q];
  assign entries_o = mem_q;
  assign valid_o   = valid_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q]   <= push_data_i;
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/writeback_ctrl.sv
// Register-file write side: queues whole-vector ALU results, assembles
// element-wise load beats, arbitrates one write per cycle and drives a
// registered write port. Also exports pending-destination masks for RAW stalls.
// Ports:
//   clk, reset                              clock, synchronous active-high reset
//   aluValid/aluReady/aluIsVec/aluDest/aluData   ALU result handshake + payload
//   memValid/memReady/memIsVec/memDest/memLane/memData/memLast  load beat handshake
//   regWrEnSc/regWrEnVec/regToWrite/dataIn  registered register-file write port
//   pendingSc/pendingVec                    destinations owned by in-flight results
module writeback_ctrl
  import asip_wb_pkg::*;
#(
  parameter int unsigned registerSize     = REG_SIZE,
  parameter int unsigned registerQuantity = REG_QTY,
  parameter int unsigned vecSize          = VEC_SIZE,
  parameter int unsigned FIFO_DEPTH       = 2
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   aluValid,
  output logic                                   aluReady,
  input  logic                                   aluIsVec,
  input  logic [RW-1:0]                          aluDest,
  input  logic [vecSize-1:0][registerSize-1:0]   aluData,
  input  logic                                   memValid,
  output logic                                   memReady,
  input  logic                                   memIsVec,
  input  logic [RW-1:0]                          memDest,
  input  logic [LW-1:0]                          memLane,
  input  logic [registerSize-1:0]                memData,
  input  logic                                   memLast,
  output logic                                   regWrEnSc,
  output logic                                   regWrEnVec,
  output logic [RW-1:0]                          regToWrite,
  output logic [vecSize-1:0][registerSize-1:0]   dataIn,
  output logic [registerQuantity-1:0]            pendingSc,
  output logic [registerQuantity-1:0]            pendingVec
);

  wb_entry_t                   alu_entry;
  wb_entry_t                   fifo_head;
  wb_entry_t [FIFO_DEPTH-1:0]  fifo_entries;
  logic      [FIFO_DEPTH-1:0]  fifo_valid;
  logic                        fifo_full;
  logic                        fifo_empty;

  asm_state_t                  asm_state_q;
  logic                        asm_isvec_q;
  logic [RW-1:0]               asm_dest_q;
  vec_data_t                   asm_buf_q;
  vec_data_t                   asm_buf_d;
  logic                        beat_isvec;
  logic                        mem_acc;
  logic                        last_grant_mem_q;
  logic                        grant_mem;
  logic                        grant_alu;

  assign alu_entry = '{isVec: aluIsVec, dest: aluDest, data: aluData};
  assign aluReady  = !fifo_full;
  assign memReady  = (asm_state_q != ASM_WAIT);
  assign mem_acc   = memValid && memReady;

  wb_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_alu_fifo (
    .clk_i       (clk),
    .reset_i     (reset),
    .push_i      (aluValid),
    .push_data_i (alu_entry),
    .pop_i       (grant_alu),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .entries_o   (fifo_entries),
    .valid_o     (fifo_valid)
  );

  // Memory wins a tie unless it also won the previous grant.
  always_comb begin
    grant_mem = (asm_state_q == ASM_WAIT) && (fifo_empty || !last_grant_mem_q);
    grant_alu = !fifo_empty && !grant_mem;
  end

  // The first beat starts from a cleared buffer; scalar loads always land in
  // lane 0, and out-of-range lanes leave the buffer untouched.
  always_comb begin
    asm_buf_d  = (asm_state_q == ASM_IDLE) ? '0 : asm_buf_q;
    beat_isvec = (asm_state_q == ASM_IDLE) ? memIsVec : asm_isvec_q;
    if (!beat_isvec) begin
      asm_buf_d[0] = memData;
    end else if ({1'b0, memLane} < (LW+1)'(vecSize)) begin
      asm_buf_d[memLane] = memData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      asm_state_q      <= ASM_IDLE;
      asm_isvec_q      <= 1'b0;
      asm_dest_q       <= '0;
      asm_buf_q        <= '0;
      last_grant_mem_q <= 1'b0;
      regWrEnSc        <= 1'b0;
      regWrEnVec       <= 1'b0;
      regToWrite       <= '0;
      dataIn           <= '0;
    end else begin
      case (asm_state_q)
        ASM_IDLE, ASM_COLLECT: begin
          if (mem_acc) begin
            asm_buf_q   <= asm_buf_d;
            asm_state_q <= memLast ? ASM_WAIT : ASM_COLLECT;
            if (asm_state_q == ASM_IDLE) begin
              asm_isvec_q <= memIsVec;
              asm_dest_q  <= memDest;
            end
          end
        end
        ASM_WAIT: begin
          if (grant_mem) asm_state_q <= ASM_IDLE;
        end
        default: asm_state_q <= ASM_IDLE;
      endcase

      regWrEnSc  <= 1'b0;
      regWrEnVec <= 1'b0;
      if (grant_mem) begin
        regWrEnVec       <= asm_isvec_q;
        regWrEnSc        <= !asm_isvec_q;
        regToWrite       <= asm_dest_q;
        dataIn           <= asm_buf_q;
        last_grant_mem_q <= 1'b1;
      end else if (grant_alu) begin
        regWrEnVec       <= fifo_head.isVec;
        regWrEnSc        <= !fifo_head.isVec;
        regToWrite       <= fifo_head.dest;
        dataIn           <= fifo_head.data;
        last_grant_mem_q <= 1'b0;
      end
    end
  end

  // A destination stays pending from queueing until the cycle its write strobe drops.
  always_comb begin
    pendingSc  = '0;
    pendingVec = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (fifo_valid[i]) begin
        if (fifo_entries[i].isVec) pendingVec = pendingVec | dest_mask(fifo_entries[i].dest);
        else                       pendingSc  = pendingSc  | dest_mask(fifo_entries[i].dest);
      end
    end
    if (asm_state_q != ASM_IDLE) begin
      if (asm_isvec_q) pendingVec = pendingVec | dest_mask(asm_dest_q);
      else             pendingSc  = pendingSc  | dest_mask(asm_dest_q);
    end
    if (regWrEnVec) pendingVec = pendingVec | dest_mask(regToWrite);
    if (regWrEnSc)  pendingSc  = pendingSc  | dest_mask(regToWrite);
  end

endmodule
